// File: rtl/rv_sdram_bridge_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SDRAM request bridge.
package rv_sdram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam int         RV_ADDR_W = 20;
  localparam logic       HALF_LO   = 1'b0;
  localparam logic       HALF_HI   = 1'b1;
  localparam logic [1:0] DS_BOTH   = 2'b11;

  // A write halfword needs an SDRAM access unless skipping is enabled and
  // neither of its byte strobes is set.
  function automatic logic half_used(input logic [1:0] strb, input logic skip_empty);
    return !skip_empty || (strb != 2'b00);
  endfunction

endpackage

// File: rtl/rv_sdram_bridge.sv
// Splits 32-bit CPU bus accesses into one or two 16-bit toggle-handshake
// SDRAM requests (low halfword first) and reassembles read data.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for mem_valid; latches the request on accept
// ISSUE   | drives halfword addr/data/ds and toggles rv_req
// WAIT    | holds request outputs until rv_req_ack matches rv_req
// CAPTURE | read only: stores rv_dout into the current halfword slot
// DONE    | one-cycle mem_ready pulse; mem_valid is not sampled here
module rv_sdram_bridge
  import rv_sdram_bridge_pkg::*;
#(
  parameter logic SKIP_EMPTY_HALF = 1'b1,
  parameter logic BIG_END         = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [20:0]          i_mem_addr,
  input  logic [31:0]          i_mem_wdata,
  input  logic [3:0]           i_mem_wstrb,
  output logic [31:0]          o_mem_rdata,
  output logic [RV_ADDR_W-1:0] o_rv_addr,
  output logic [15:0]          o_rv_din,
  output logic [1:0]           o_rv_ds,
  output logic                 o_rv_we,
  output logic                 o_rv_req,
  input  logic                 i_rv_req_ack,
  input  logic [15:0]          i_rv_dout
);

  state_e      r_state;
  state_e      w_next;
  logic [18:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_is_read;
  logic        r_half;
  logic        r_more;
  logic [15:0] r_rbuf_lo;
  logic [31:0] r_rdata;
  logic [RV_ADDR_W-1:0] r_rv_addr;
  logic [15:0] r_rv_din;
  logic [1:0]  r_rv_ds;
  logic        r_rv_we;
  logic        r_rv_req;

  logic        w_acked;
  logic        w_lo_used;
  logic        w_hi_used;
  logic [1:0]  w_issue_ds;
  logic [15:0] w_issue_din;
  logic        w_unused;

  // Byte-offset bits of the word address carry no information here.
  assign w_unused    = ^i_mem_addr[1:0];

  assign w_acked     = (i_rv_req_ack == r_rv_req);
  assign w_lo_used   = half_used(i_mem_wstrb[1:0], SKIP_EMPTY_HALF);
  assign w_hi_used   = half_used(i_mem_wstrb[3:2], SKIP_EMPTY_HALF);
  assign w_issue_ds  = r_is_read ? DS_BOTH :
                       ((r_half == HALF_HI) ? r_wstrb[3:2] : r_wstrb[1:0]);
  assign w_issue_din = (r_half == HALF_HI) ? r_wdata[31:16] : r_wdata[15:0];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_mem_valid) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = ST_WAIT;
      ST_WAIT:    if (w_acked) w_next = r_is_read ? ST_CAPTURE :
                                        (r_more ? ST_ISSUE : ST_DONE);
      ST_CAPTURE: w_next = r_more ? ST_ISSUE : ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Request latching, SDRAM request registers and read-data assembly.
  // On reset rv_req is resynchronised to the ack so any in-flight access
  // from an abandoned transaction looks already completed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rv_req  <= i_rv_req_ack;
      r_rv_we   <= 1'b0;
      r_rv_ds   <= 2'b00;
      r_rv_addr <= '0;
      r_rv_din  <= '0;
      r_rdata   <= '0;
      r_rbuf_lo <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_is_read <= 1'b0;
      r_half    <= HALF_LO;
      r_more    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mem_valid) begin
            r_addr    <= i_mem_addr[20:2];
            r_wdata   <= i_mem_wdata;
            r_wstrb   <= i_mem_wstrb;
            r_is_read <= (i_mem_wstrb == 4'b0000);
            if (i_mem_wstrb == 4'b0000) begin
              r_half <= HALF_LO;
              r_more <= 1'b1;
            end else begin
              r_half <= w_lo_used ? HALF_LO : HALF_HI;
              r_more <= w_lo_used && w_hi_used;
            end
          end
        end
        ST_ISSUE: begin
          r_rv_addr <= {r_addr, r_half ^ BIG_END};
          r_rv_din  <= w_issue_din;
          r_rv_ds   <= w_issue_ds;
          r_rv_we   <= !r_is_read;
          r_rv_req  <= ~r_rv_req;
        end
        ST_WAIT: begin
          if (w_acked && !r_is_read && r_more) begin
            r_half <= HALF_HI;
            r_more <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (r_half == HALF_LO) r_rbuf_lo <= i_rv_dout;
          else                   r_rdata   <= {i_rv_dout, r_rbuf_lo};
          if (r_more) begin
            r_half <= HALF_HI;
            r_more <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_ready = (r_state == ST_DONE);
  assign o_mem_rdata = r_rdata;
  assign o_rv_addr   = r_rv_addr;
  assign o_rv_din    = r_rv_din;
  assign o_rv_ds     = r_rv_ds;
  assign o_rv_we     = r_rv_we;
  assign o_rv_req    = r_rv_req;

endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Bench for rv_sdram_bridge: table of directed accesses against a
// behavioural toggle-handshake controller, plus reset, back-to-back and
// no-skip sequences.
module tb_rv_sdram_bridge;

  logic        clk = 1'b0;
  logic        r_reset;
  logic        sel;
  logic        mem_valid;
  logic [20:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] rv_dout;
  logic        w_ack;

  logic        ready_a, ready_b, we_a, we_b, req_a, req_b;
  logic [31:0] rdata_a, rdata_b;
  logic [19:0] addr_a, addr_b;
  logic [15:0] din_a, din_b;
  logic [1:0]  ds_a, ds_b;

  logic        w_ready, w_we, w_req;
  logic [31:0] w_rdata;
  logic [19:0] w_addr;
  logic [15:0] w_din;
  logic [1:0]  w_ds;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv_sdram_bridge #(.SKIP_EMPTY_HALF(1'b1), .BIG_END(1'b0)) u_dut (
    .i_clk(clk), .i_reset(r_reset), .i_mem_valid(mem_valid & ~sel),
    .o_mem_ready(ready_a), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_mem_wstrb(mem_wstrb), .o_mem_rdata(rdata_a), .o_rv_addr(addr_a),
    .o_rv_din(din_a), .o_rv_ds(ds_a), .o_rv_we(we_a), .o_rv_req(req_a),
    .i_rv_req_ack(w_ack), .i_rv_dout(rv_dout));

  rv_sdram_bridge #(.SKIP_EMPTY_HALF(1'b0), .BIG_END(1'b0)) u_dut_noskip (
    .i_clk(clk), .i_reset(r_reset), .i_mem_valid(mem_valid & sel),
    .o_mem_ready(ready_b), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_mem_wstrb(mem_wstrb), .o_mem_rdata(rdata_b), .o_rv_addr(addr_b),
    .o_rv_din(din_b), .o_rv_ds(ds_b), .o_rv_we(we_b), .o_rv_req(req_b),
    .i_rv_req_ack(w_ack), .i_rv_dout(rv_dout));

  assign w_ready = sel ? ready_b : ready_a;
  assign w_rdata = sel ? rdata_b : rdata_a;
  assign w_addr  = sel ? addr_b  : addr_a;
  assign w_din   = sel ? din_b   : din_a;
  assign w_ds    = sel ? ds_b    : ds_a;
  assign w_we    = sel ? we_b    : we_a;
  assign w_req   = sel ? req_b   : req_a;

  // ---------------- controller model ----------------
  int          m_n = 1;
  logic        m_manual;
  logic        man_ack;
  logic        m_base;
  int          m_age;
  logic        m_pend, m_fire;
  int          log_cnt = 0;
  logic [19:0] log_addr [0:255];
  logic [15:0] log_din  [0:255];
  logic [1:0]  log_ds   [0:255];
  logic        log_we   [0:255];

  function automatic logic [15:0] rd_val(input logic [19:0] a);
    if (a == 20'h00082) return 16'hBEEF;
    if (a == 20'h00083) return 16'hDEAD;
    return {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  assign m_pend = (w_req != m_base);
  assign m_fire = !m_manual && !r_reset && m_pend && ((m_age + 1) >= m_n);
  assign w_ack  = m_manual ? man_ack : (r_reset ? m_base : (m_fire ? w_req : m_base));

  always @(posedge clk) begin
    if (m_manual) begin
      m_base <= man_ack;
      m_age  <= 0;
    end else if (r_reset) begin
      m_base <= 1'b0;
      m_age  <= 0;
    end else if (m_fire) begin
      m_base  <= w_req;
      m_age   <= 0;
      rv_dout <= rd_val(w_addr);
      if (log_cnt < 256) begin
        log_addr[log_cnt] <= w_addr;
        log_din[log_cnt]  <= w_din;
        log_ds[log_cnt]   <= w_ds;
        log_we[log_cnt]   <= w_we;
      end
      log_cnt <= log_cnt + 1;
    end else if (m_pend) begin
      m_age <= m_age + 1;
    end
  end

  // ---------------- toggle-while-pending monitor ----------------
  logic prev_req, prev_ack;
  logic prev_rst = 1'b1;
  int   viol = 0;
  always @(negedge clk) begin
    if (!prev_rst && (w_req !== prev_req) && (prev_req !== prev_ack)) viol <= viol + 1;
    prev_req <= w_req;
    prev_ack <= w_ack;
    prev_rst <= r_reset;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input logic [20:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [31:0] rd, output logic to);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    lat = 0; to = 1'b1; rd = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      if (w_ready) begin
        to = 1'b0;
        rd = w_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  task automatic do_reset(input logic new_sel);
    @(posedge clk); #1 r_reset = 1'b1;
    @(posedge clk); #1 sel = new_sel;
    repeat (3) @(posedge clk);
    #1 r_reset = 1'b0;
  endtask

  typedef struct {
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          n;
    logic [31:0] exp_rdata;
    int          exp_nreq;
    logic [19:0] a0; logic [15:0] d0; logic [1:0] s0;
    logic [19:0] a1; logic [15:0] d1; logic [1:0] s1;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [6];
  int          lat, lat2, lc, rdy_seen;
  logic [31:0] rd;
  logic        to;

  initial begin
    vecs[0] = '{21'h000104, 32'h0, 4'b0000, 3, 32'hDEADBEEF, 2,
                20'h00082, 16'h0, 2'b11, 20'h00083, 16'h0, 2'b11, 12};
    vecs[1] = '{21'h000010, 32'h12345678, 4'b1111, 3, 32'hDEADBEEF, 2,
                20'h00008, 16'h5678, 2'b11, 20'h00009, 16'h1234, 2'b11, 10};
    vecs[2] = '{21'h000020, 32'hAABBCCDD, 4'b0100, 2, 32'hDEADBEEF, 1,
                20'h00011, 16'hAABB, 2'b01, 20'h0, 16'h0, 2'b00, 5};
    vecs[3] = '{21'h000107, 32'h0, 4'b0000, 0, 32'hDEADBEEF, 2,
                20'h00082, 16'h0, 2'b11, 20'h00083, 16'h0, 2'b11, 8};
    vecs[4] = '{21'h000040, 32'h11223344, 4'b0011, 1, 32'hDEADBEEF, 1,
                20'h00020, 16'h3344, 2'b11, 20'h0, 16'h0, 2'b00, 4};
    vecs[5] = '{21'h000200, 32'h0, 4'b0000, 2, 32'h5B015A00, 2,
                20'h00100, 16'h0, 2'b11, 20'h00101, 16'h0, 2'b11, 10};

    r_reset = 1'b1; sel = 1'b0; mem_valid = 1'b0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; m_manual = 1'b0; man_ack = 1'b0; m_n = 1;
    repeat (4) @(posedge clk);
    #1 r_reset = 1'b0;

    @(negedge clk);
    check("rst_ready", w_ready, 0);
    check("rst_rdata", w_rdata, 0);
    check("rst_we", w_we, 0);
    check("rst_ds", w_ds, 0);
    check("rst_req", w_req, 0);

    for (int i = 0; i < 6; i++) begin
      m_n = vecs[i].n;
      lc  = log_cnt;
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rd, to);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_nreq", i), log_cnt - lc, vecs[i].exp_nreq);
      check($sformatf("v%0d_a0", i), log_addr[lc], vecs[i].a0);
      check($sformatf("v%0d_ds0", i), log_ds[lc], vecs[i].s0);
      check($sformatf("v%0d_we0", i), log_we[lc], vecs[i].wstrb != 4'b0000);
      if (vecs[i].wstrb != 4'b0000)
        check($sformatf("v%0d_din0", i), log_din[lc], vecs[i].d0);
      if (vecs[i].exp_nreq == 2) begin
        check($sformatf("v%0d_a1", i), log_addr[lc+1], vecs[i].a1);
        check($sformatf("v%0d_ds1", i), log_ds[lc+1], vecs[i].s1);
        if (vecs[i].wstrb != 4'b0000)
          check($sformatf("v%0d_din1", i), log_din[lc+1], vecs[i].d1);
      end
      @(negedge clk);
      check($sformatf("v%0d_ready_pulse", i), w_ready, 0);
    end

    // Back-to-back reads with mem_valid held across DONE.
    m_n = 1;
    lc  = log_cnt;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 21'h000104; mem_wstrb = 4'b0000;
    lat = 0; to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); lat++;
      if (w_ready) begin to = 1'b0; break; end
    end
    check("b2b_first_lat", lat, 8);
    check("b2b_first_rdata", w_rdata, 32'hDEADBEEF);
    lat2 = 0; to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); lat2++;
      if (lat2 == 1) check("b2b_ready_one_cycle", w_ready, 0);
      if (w_ready) begin to = 1'b0; break; end
    end
    check("b2b_timeout", to, 0);
    check("b2b_second_lat", lat2, 8);
    check("b2b_second_rdata", w_rdata, 32'hDEADBEEF);
    @(posedge clk); #1 mem_valid = 1'b0;
    check("b2b_nreq", log_cnt - lc, 4);

    // Reset during WAIT with a late ack afterwards.
    @(posedge clk); #1 m_manual = 1'b1; man_ack = 1'b0; r_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 r_reset = 1'b0;
    @(negedge clk);
    check("man_req_sync", w_req, 0);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 21'h000104; mem_wstrb = 4'b0000;
    repeat (3) @(negedge clk);
    check("wait_req_toggled", w_req, 1);
    @(posedge clk); #1 r_reset = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1 r_reset = 1'b0;
    @(negedge clk);
    check("midwait_rst_req", w_req, 0);
    check("midwait_rst_ready", w_ready, 0);
    @(posedge clk); #1 man_ack = 1'b1;
    rdy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (w_ready) rdy_seen++;
    end
    check("late_ack_no_ready", rdy_seen, 0);
    check("late_ack_req_hold", w_req, 0);
    @(posedge clk); #1 r_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 r_reset = 1'b0; m_manual = 1'b0;
    @(negedge clk);
    check("resync_req", w_req, 1);

    // SKIP_EMPTY_HALF = 0: empty low halfword still issued.
    do_reset(1'b1);
    m_n = 2;
    lc  = log_cnt;
    do_access(21'h000020, 32'hAABBCCDD, 4'b0100, lat, rd, to);
    check("noskip_timeout", to, 0);
    check("noskip_lat", lat, 8);
    check("noskip_nreq", log_cnt - lc, 2);
    check("noskip_a0", log_addr[lc], 20'h00010);
    check("noskip_ds0", log_ds[lc], 2'b00);
    check("noskip_din0", log_din[lc], 16'hCCDD);
    check("noskip_a1", log_addr[lc+1], 20'h00011);
    check("noskip_ds1", log_ds[lc+1], 2'b01);
    check("noskip_din1", log_din[lc+1], 16'hAABB);
    check("noskip_rdata", rd, 32'h0);

    @(negedge clk);
    check("no_toggle_while_pending", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv_sdram_bridge.md
Name: rv_sdram_bridge

Overview:
- Upstream adapter between the RISC-V softcore's 32-bit native memory bus (valid/ready, byte strobes) and the 16-bit toggle-handshake RV channel of the NES SDRAM controller.
- Splits each 32-bit access into one or two 16-bit SDRAM accesses: low halfword first, then high.
- Skips halfwords whose write strobes are all zero.
- Reassembles read data and returns it with a single-cycle ready pulse.

Parameters:
- SKIP_EMPTY_HALF, 1, when 1 a write halfword whose two strobe bits are 0 issues no SDRAM access; when 0, both halfwords are always issued.
- BIG_END, 0, when 1 the halfword order on the SDRAM side is swapped (high halfword at even word address).

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  CPU request valid; held high until mem_ready.
- mem_ready  out  1  one-cycle completion pulse.
- mem_addr  in  21  byte address in the 2MB RV space; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_rdata  out  32  read data; valid in the mem_ready cycle, held until the next read completes.
- rv_addr  out  20  halfword address to the controller (byte address bits [20:1]).
- rv_din  out  16  halfword write data.
- rv_ds  out  2  halfword byte enables (bit1 = upper byte).
- rv_we  out  1  1 = write.
- rv_req  out  1  request toggle.
- rv_req_ack  in  1  controller acknowledge toggle.
- rv_dout  in  16  controller read data; valid the clk after the ack toggle is seen.

Behaviour:
- Handshake (controller side):
  - A request is pending while rv_req != rv_req_ack.
  - To issue a request, the bridge drives rv_addr/rv_din/rv_ds/rv_we and inverts rv_req in the same cycle.
  - The bridge holds those outputs stable until rv_req_ack == rv_req.
  - The bridge never toggles rv_req while a request is pending.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - On mem_valid, latch addr/wdata/wstrb and set half = 0.
  - Compute the halfword list: read = {lo, hi}; write = halves with a nonzero strobe pair when SKIP_EMPTY_HALF, else both.
  - An empty list (write with wstrb = 0 cannot occur, since wstrb = 0 means read) is not reachable.
  - Go to ISSUE.
- ISSUE:
  - rv_addr = {latched_addr[20:2], half ^ BIG_END}.
  - rv_ds = wstrb pair for that half (reads: 2'b11).
  - rv_din = the matching wdata halfword.
  - Toggle rv_req, then go to WAIT.
- WAIT: when rv_req_ack == rv_req, go to CAPTURE on a read, or to next-half/DONE on a write.
- CAPTURE (read only): sample rv_dout into rdata half slot (lo → [15:0], hi → [31:16]). If another half remains, return to ISSUE; else go to DONE.
- DONE:
  - Assert mem_ready for exactly one cycle, drive mem_rdata, return to IDLE.
  - mem_valid is not resampled in the DONE cycle; the earliest new accept is the cycle after DONE.
- Latency (controller ack after N clk):
  - Read = 1 (accept) + 2×(1 issue + N wait + 1 capture) + 1 done.
  - A single-half write drops one issue/wait pair.
- Reset:
  - mem_ready = 0, mem_rdata = 0, state = IDLE.
  - rv_req <= rv_req_ack, so no request is spuriously outstanding; rv_we = 0, rv_ds = 0.
  - Reset mid-WAIT abandons the transaction. The controller may still complete an in-flight access; the bridge ignores it because rv_req was resynchronised to ack at reset.
- mem_valid dropping before ready is a protocol violation; the bridge completes the latched transaction regardless.
- rv_req_ack toggling while no request is pending (rv_req == rv_req_ack on entry to IDLE) is ignored.
- Write data order is fixed: the low halfword is always written before the high halfword, BIG_END affects only address mapping.

Decomposition:
- Shared package holds:
  - state enum (IDLE/ISSUE/WAIT/CAPTURE/DONE)
  - RV_ADDR_W = 20
  - HALF_LO = 0 / HALF_HI = 1
  - DS_BOTH = 2'b11
- Single module; no sub-module required.
- The bench provides a behavioural controller model that acks after a programmable N cycles and presents rv_dout one cycle later.

Test Plan:
- Read, mem_addr = 21'h000104, model returns 16'hBEEF (lo) then 16'hDEAD (hi), N = 3 → rv_addr = 20'h00082 then 20'h00083; mem_rdata = 32'hDEADBEEF; mem_ready one cycle, 12 clk after accept.
- Write, wstrb = 4'b1111, wdata = 32'h12345678, addr 21'h000010 → two requests: (20'h00008, 16'h5678, ds 11) then (20'h00009, 16'h1234, ds 11); rv_we = 1.
- Write, wstrb = 4'b0100, SKIP_EMPTY_HALF = 1 → exactly one rv_req toggle: rv_addr = 20'h…1, rv_ds = 2'b01; with SKIP_EMPTY_HALF = 0 → two toggles, the first with ds = 2'b00.
- Reset asserted during WAIT with rv_req = 1, rv_req_ack = 0 → next cycle rv_req == rv_req_ack, mem_ready = 0; a late ack toggle from the model produces no mem_ready.
- mem_valid held high across DONE for back-to-back reads → the second access is accepted no earlier than one cycle after the mem_ready pulse; rv_req is never toggled while pending (assertion).
- Ack arriving in the same cycle as ISSUE (N = 0 model) → no lost or duplicated halfword; read data is correct.
